uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter byte input among NUM_REQ requesters. Each requester sends messages (byte bursts ending in last).
//  Messages are atomic: once granted, a requester keeps the link until its last byte; grants rotate round-robin.
//  Sits between client blocks and the transmitter's FIFO write port (data/write/full).
// PARAMETERS
//  NUM_REQ       4    number of requesters, 2..16
//  IDLE_TIMEOUT  255  max consecutive mid-message cycles with granted valid low before grant is revoked, 1..65535
// PORTS
//  clock_i        in   1          system clock
//  reset_n_i      in   1          asynchronous active-low reset
//  req_valid_i    in   NUM_REQ    per-requester byte valid
//  req_data_i     in   NUM_REQ*8  per-requester byte; requester k on bits [8k+7:8k]
//  req_last_i     in   NUM_REQ    byte is final byte of message
//  req_ready_o    out  NUM_REQ    byte accepted when valid&ready
//  buffer_full_i  in   1          transmitter FIFO at/above full threshold
//  data_o         out  8          byte to transmitter FIFO
//  data_write_o   out  1          one-cycle write strobe for data_o
//  grant_o        out  NUM_REQ    one-hot current owner, 0 when idle
//  busy_o         out  1          message in progress
//  timeout_o      out  1          one-cycle pulse, grant revoked by timeout
// BEHAVIOUR
//  Reset: state IDLE, rr pointer = NUM_REQ-1 (so req 0 wins first), all outputs 0, timeout counter 0.
//  FSM states IDLE, HDR (only with UART_ARB_HEADER_EN), XFER.
//  IDLE: if any req_valid_i, pick first set index scanning ptr+1, ptr+2, ... mod NUM_REQ.
//   Register grant_o, ptr <= winner, busy_o <= 1. Next state is XFER (or HDR). No byte accepted in the IDLE cycle.
//  XFER: req_ready_o[g] = !buffer_full_i; other ready bits 0.
//   On valid&ready: data_o <= byte, data_write_o <= 1 next cycle (1-cycle latency); otherwise data_write_o <= 0.
//   On accepted byte with last=1: grant_o <= 0, busy_o <= 0, go IDLE; re-arbitration starts the following cycle.
//  Backpressure: buffer_full_i is sampled combinationally into ready. Because of the registered write,
//   the transmitter full threshold must be <= depth-2. The arbiter never writes while the full input is high at acceptance.
//  Timeout: counter increments each XFER cycle with req_valid_i[g]=0 and clears on any accepted byte.
//   Stalls caused by full do not count. Counter reaching IDLE_TIMEOUT: timeout_o pulses 1 cycle,
//   grant_o <= 0, go IDLE; the partial message is not terminated on the line.
//  Non-granted requesters are never acked; their valid/data may change freely.
//  Simultaneous last byte and new requests: released owner has lowest priority next round.
//  Reset mid-message: all state cleared immediately; a write strobe in flight is dropped.
//  Counter width 16 bits; pointer width $clog2(NUM_REQ); wrap mod NUM_REQ (non-power-of-2 handled).
// CONFIGURATION
//  UART_ARB_HEADER_EN defined: after a grant, state HDR emits one header byte before the first payload byte:
//   header = {HDR_TAG=4'hA, id[3:0]} with id = granted index, written when !buffer_full_i.
//   No requester ready in HDR; timeout counter idle in HDR.
//  UART_ARB_HEADER_EN undefined: HDR state absent, IDLE -> XFER directly, raw payload only.
// STRUCTURE
//  Package uart_arb_pkg: state encoding constants (IDLE/HDR/XFER), HDR_TAG, PTR_W/CNT_W helpers, max NUM_REQ=16.
//  Sub-module rr_picker: combinational round-robin first-set scan (req vector, ptr) -> one-hot grant + index + any.
//  Top holds FSM, pointer, timeout counter, output registers.
// TESTING
//  1. Req0 sends 3 bytes 11,22,33 (last on 33), full=0 -> grant_o=0001 one cycle after valid;
//     data_write_o strobes 11,22,33 on consecutive cycles; busy_o drops after 33.
//  2. Req1 and req3 both valid from IDLE after req1 owned last -> req3 granted first, req1 after req3's last; no interleaved bytes.
//  3. buffer_full_i high 10 cycles mid-message -> req_ready_o=0, no writes, timeout_o stays 0; resumes with next byte intact.
//  4. IDLE_TIMEOUT=8, owner drops valid mid-message -> timeout_o pulse exactly 8 cycles later, grant_o=0, next requester served.
//  5. UART_ARB_HEADER_EN, req2 sends 0x55 last -> writes 0xA2 then 0x55.
//  6. reset_n_i low during XFER with write pending -> all outputs 0 asynchronously; after release req0 wins first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// header tag, counter width and pointer-width helper.
package uart_arb_pkg;

  localparam int         MAX_NUM_REQ = 16;
  localparam int         CNT_W       = 16;
  localparam logic [3:0] HDR_TAG     = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Pointer width for n requesters; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans req starting at ptr+1 (mod
// NUM_REQ) and returns the first set requester as one-hot, index and any.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;

  // First-set scan from ptr+1; the previous winner is looked at last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter FIFO write port among
// NUM_REQ message-oriented requesters. A granted requester owns the link
// until its last byte or until it idles for IDLE_TIMEOUT cycles.
// Optional feature macro: UART_ARB_HEADER_EN (emit {HDR_TAG, id} before
// each message payload).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 buffer_full_i,
  output logic [7:0]           data_o,
  output logic                 data_write_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int               PTR_W    = ptr_w(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [7:0]          data_q, data_d;
  logic                write_q, write_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;

  logic                own_valid;
  logic                own_last;
  logic [7:0]          own_data;
  logic                accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The owner's handshake signals, selected through the one-hot grant.
  assign own_valid = |(req_valid_i & grant_q);
  assign own_last  = |(req_last_i & grant_q);
  assign accept    = (state_q == ST_XFER) && own_valid && !buffer_full_i;

  // Owner's data byte, OR-reduced over the one-hot grant.
  always_comb begin
    own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) own_data |= req_data_i[8*k +: 8];
    end
  end

  // Ready follows full combinationally and only the owner is ever acked.
  assign req_ready_o = (state_q == ST_XFER && !buffer_full_i) ? grant_q : '0;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    data_d    = data_q;
    write_d   = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          ptr_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef UART_ARB_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      ST_HDR: begin
        // ptr_q holds the owner's index for the whole message.
        if (!buffer_full_i) begin
          data_d  = {HDR_TAG, 4'(ptr_q)};
          write_d = 1'b1;
          state_d = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        if (accept) begin
          data_d  = own_data;
          write_d = 1'b1;
          cnt_d   = '0;
          if (own_last) begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (!own_valid) begin
          // Full-induced stalls (valid high) leave the counter untouched.
          if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            grant_d   = '0;
            busy_d    = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything, dropping any
  // write strobe in flight.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      write_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      write_q   <= write_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign data_o       = data_q;
  assign data_write_o = write_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester message queues
// drive the DUT, a transaction-level model predicts grant/busy/timeout/
// ready and pushes expected FIFO writes into a scoreboard queue that a
// separate monitor drains.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef UART_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic           clock_i = 1'b0;
  logic           reset_n_i;
  logic [N-1:0]   req_valid_i;
  logic [N*8-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic           buffer_full_i;
  logic [7:0]     data_o;
  logic           data_write_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;

  always #5 clock_i = ~clock_i;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clock_i       (clock_i),
    .reset_n_i     (reset_n_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_last_i    (req_last_i),
    .req_ready_o   (req_ready_o),
    .buffer_full_i (buffer_full_i),
    .data_o        (data_o),
    .data_write_o  (data_write_o),
    .grant_o       (grant_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o)
  );

  typedef struct {
    logic [7:0] data;
    bit         last;
    int         gap;   // cycles with valid low before this byte is offered
  } item_t;

  item_t      src_q[N][$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         full_hold = 0;
  int         full_pct  = 0;
  bit         last_push = 0;

  // Reference model: owner (-1 = idle), round-robin pointer, idle count.
  int         m_owner = -1;
  int         m_ptr   = N - 1;
  int         m_cnt   = 0;
  bit         m_hdr   = 0;
  logic [N-1:0] m_grant = '0;
  logic       m_busy    = 1'b0;
  logic       m_timeout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_hdr = 0;
    m_grant = '0; m_busy = 1'b0; m_timeout = 1'b0;
  endfunction

  task automatic add_byte(input int k, input logic [7:0] d, input bit last, input int gap);
    item_t it;
    it.data = d; it.last = last; it.gap = gap;
    src_q[k].push_back(it);
  endtask

  task automatic add_msg(input int k, input int len, input bit allow_timeout);
    int g;
    for (int i = 0; i < len; i++) begin
      g = ($urandom_range(7) == 0) ? int'($urandom_range(1, 4)) : 0;
      if (allow_timeout && $urandom_range(29) == 0) g = TO + 3;
      add_byte(k, 8'($urandom), (i == len - 1), g);
    end
  endtask

  // One clock: check registered outputs, drive new inputs, check ready,
  // then advance the model across the coming rising edge.
  task automatic cycle();
    logic [N-1:0]   v, l, rdy;
    logic [N*8-1:0] d;
    bit             full;
    int             w;
    item_t          it;
    @(negedge clock_i);
    check("grant", 32'(grant_o), 32'(m_grant));
    check("busy", 32'(busy_o), 32'(m_busy));
    check("timeout", 32'(timeout_o), 32'(m_timeout));
    v = '0; l = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      d[8*k +: 8] = 8'($urandom);
      l[k]        = 1'($urandom);
      if (src_q[k].size() > 0) begin
        it = src_q[k][0];
        if (it.gap > 0) begin
          it.gap--;
          src_q[k][0] = it;
        end else begin
          v[k]        = 1'b1;
          d[8*k +: 8] = it.data;
          l[k]        = it.last;
        end
      end
    end
    if (full_hold > 0) begin
      full = 1'b1;
      full_hold--;
    end else begin
      full = ($urandom_range(99) < full_pct);
    end
    req_valid_i   = v;
    req_data_i    = d;
    req_last_i    = l;
    buffer_full_i = full;
    #1;
    rdy = '0;
    if (m_owner >= 0 && !m_hdr && !full) rdy[m_owner] = 1'b1;
    check("ready", 32'(req_ready_o), 32'(rdy));
    last_push = 0;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        w = (m_ptr + i) % N;
        if (v[w]) begin
          m_owner = w; m_ptr = w; m_cnt = 0; m_hdr = HDR_EN;
          break;
        end
      end
    end else if (m_hdr) begin
      if (!full) begin
        exp_q.push_back({4'hA, 4'(m_owner)});
        last_push = 1;
        m_hdr = 0;
      end
    end else if (v[m_owner] && !full) begin
      it = src_q[m_owner].pop_front();
      exp_q.push_back(it.data);
      last_push = 1;
      m_cnt = 0;
      if (it.last) m_owner = -1;
    end else if (!v[m_owner]) begin
      m_cnt++;
      if (m_cnt == TO) begin
        m_timeout = 1'b1;
        m_owner = -1;
        m_cnt = 0;
      end
    end
    m_grant = '0;
    if (m_owner >= 0) m_grant[m_owner] = 1'b1;
    m_busy = (m_owner >= 0);
  endtask

  // Run until all queued traffic has been written, within a cycle budget.
  task automatic drain(input int budget);
    int c = 0;
    while ((any_pending() || m_owner >= 0 || exp_q.size() > 0) && c < budget) begin
      cycle();
      c++;
    end
    check("drain_budget", 32'(c >= budget), 32'd0);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock_i);
      if (reset_n_i === 1'b1 && data_write_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("write_strobe", 32'(data_write_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_data", 32'(data_o), 32'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i     = 1'b0;
    req_valid_i   = '0;
    req_data_i    = '0;
    req_last_i    = '0;
    buffer_full_i = 1'b0;
    #1;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_write", 32'(data_write_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    #21 reset_n_i = 1'b1;

    // Req0 sends 11,22,33 with no backpressure.
    add_byte(0, 8'h11, 0, 0);
    add_byte(0, 8'h22, 0, 0);
    add_byte(0, 8'h33, 1, 0);
    drain(50);

    // Req1 owns, then req1 and req3 compete: req3 must win first.
    add_msg(1, 2, 0);
    drain(50);
    add_byte(1, 8'hB1, 0, 0);
    add_byte(1, 8'hB2, 1, 0);
    add_byte(3, 8'hD1, 0, 0);
    add_byte(3, 8'hD2, 1, 0);
    cycle();
    cycle();
    check("rr_req3_first", 32'(grant_o), 32'h8);
    drain(50);

    // Ten cycles of full mid-message: no writes, no timeout.
    for (int i = 0; i < 6; i++) add_byte(0, 8'(8'h40 + i), (i == 5), 0);
    cycle();
    cycle();
    cycle();
    full_hold = 10;
    drain(80);

    // Owner stalls past the idle timeout while req2 waits.
    add_byte(0, 8'hA0, 0, 0);
    add_byte(0, 8'hA1, 0, TO + 6);
    add_byte(0, 8'hA2, 1, 0);
    add_byte(2, 8'hC0, 0, 3);
    add_byte(2, 8'hC1, 1, 0);
    drain(120);

    // Single-byte message from req2 (header precedes it when enabled).
    add_byte(2, 8'h55, 1, 0);
    drain(30);

    // Randomized traffic with random backpressure.
    full_pct = 25;
    for (int b = 0; b < 25; b++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(2) != 0) add_msg(k, int'($urandom_range(1, 6)), 1);
        if ($urandom_range(3) == 0) add_msg(k, int'($urandom_range(1, 3)), 0);
      end
      drain(3000);
    end
    full_pct = 0;

    // Reset while a write strobe is in flight.
    add_msg(0, 4, 0);
    add_msg(1, 4, 0);
    begin
      int c = 0;
      cycle();
      while (!last_push && c < 50) begin
        cycle();
        c++;
      end
      check("reset_setup_budget", 32'(c >= 50), 32'd0);
    end
    @(posedge clock_i);
    #2;
    check("write_before_reset", 32'(data_write_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_write", 32'(data_write_o), 32'd0);
    check("mid_rst_timeout", 32'(timeout_o), 32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    model_reset();
    #1 reset_n_i = 1'b1;
    for (int k = 0; k < N; k++) add_byte(k, 8'(8'hE0 + k), 1, 0);
    cycle();
    cycle();
    check("post_rst_req0_first", 32'(grant_o), 32'h1);
    drain(60);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
